// File: rtl/uart_bus_master.sv
// UART command bridge acting as a secondary bus master: 8N1 rx/tx plus a frame parser issuing single-cycle reads/writes.
// Optional partial-frame abort counter enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_bus_master #(
   parameter int unsigned CLKS_PER_BIT = 10417,
   parameter int unsigned TIMEOUT_CLKS = 1041700
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Rx_Serial,
   output logic        Tx_Serial,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] Address,
   output logic [31:0] Write_data,
   input  logic [31:0] Read_data,
   output logic        Busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] REPLY_ACK = 8'h4B;
   localparam logic [7:0] REPLY_UNK = 8'h3F;

   // ---------------- receiver ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   rx_state_e        rx_state_q, rx_state_d;
   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             byte_valid_q, byte_valid_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         byte_valid_q <= 1'b0;
      end else begin
         rx_meta_q    <= Rx_Serial;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         byte_valid_q <= byte_valid_d;
      end
   end

   // Edge-triggered start so a line held low after a framing error cannot restart a character.
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q + CNT_W'(1);
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      byte_valid_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == BIT_HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               byte_valid_d = rx_sync_q;
               rx_state_d   = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- transmitter ----------------
   logic             tx_q, tx_busy_q;
   logic [9:0]       tx_shift_q;
   logic [3:0]       tx_bit_q;
   logic [CNT_W-1:0] tx_cnt_q;
   logic             tx_load_c, tx_done_c;
   logic [7:0]       tx_byte_c;

   assign tx_done_c = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

   // A load in the stop bit's last cycle chains the next byte with no idle gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_shift_q <= '1;
         tx_bit_q   <= '0;
         tx_cnt_q   <= '0;
      end else if (tx_load_c) begin
         tx_q       <= 1'b0;
         tx_busy_q  <= 1'b1;
         tx_shift_q <= {1'b1, tx_byte_c, 1'b0};
         tx_bit_q   <= '0;
         tx_cnt_q   <= '0;
      end else if (tx_busy_q) begin
         if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
               tx_busy_q <= 1'b0;
               tx_q      <= 1'b1;
            end else begin
               tx_bit_q   <= tx_bit_q + 4'd1;
               tx_shift_q <= {1'b1, tx_shift_q[9:1]};
               tx_q       <= tx_shift_q[1];
            end
         end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
         end
      end
   end

   // ---------------- frame parser ----------------
   typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADDR, F_DATA, F_EXEC, F_REPLY} frame_state_e;

   frame_state_e f_state_q, f_state_d;
   logic         is_write_q, is_write_d;
   logic [7:0]   cmd_q, cmd_d;
   logic [1:0]   byte_cnt_q, byte_cnt_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  wdata_q, wdata_d;
   logic [23:0]  reply_q, reply_d;
   logic [1:0]   reply_left_q, reply_left_d;
   logic         mem_read_q, mem_read_d;
   logic         mem_write_q, mem_write_d;
   logic         busy_q, busy_d;
   logic         timeout_c;

`ifdef UART_BRIDGE_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);
   logic [TO_W-1:0] to_cnt_q;

   assign timeout_c = (to_cnt_q == TO_W'(TIMEOUT_CLKS));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q <= '0;
      end else if (byte_valid_q || !(f_state_q inside {F_ADDR, F_DATA})) begin
         to_cnt_q <= '0;
      end else if (!timeout_c) begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end
   end
`else
   logic [31:0] unused_timeout_clks;
   assign unused_timeout_clks = TIMEOUT_CLKS;
   assign timeout_c           = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_state_q    <= F_IDLE;
         is_write_q   <= 1'b0;
         cmd_q        <= '0;
         byte_cnt_q   <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         reply_q      <= '0;
         reply_left_q <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         f_state_q    <= f_state_d;
         is_write_q   <= is_write_d;
         cmd_q        <= cmd_d;
         byte_cnt_q   <= byte_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         reply_q      <= reply_d;
         reply_left_q <= reply_left_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         busy_q       <= busy_d;
      end
   end

   // Strobes are registered from the next state so they line up exactly with the EXEC cycle.
   always_comb begin
      f_state_d    = f_state_q;
      is_write_d   = is_write_q;
      cmd_d        = cmd_q;
      byte_cnt_d   = byte_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      reply_d      = reply_q;
      reply_left_d = reply_left_q;
      tx_load_c    = 1'b0;
      tx_byte_c    = 8'h00;
      case (f_state_q)
         F_IDLE: begin
            if (byte_valid_q) begin
               cmd_d     = rx_shift_q;
               f_state_d = F_CMD;
            end
         end
         F_CMD: begin
            byte_cnt_d = '0;
            if (cmd_q == CMD_WRITE || cmd_q == CMD_READ) begin
               is_write_d = (cmd_q == CMD_WRITE);
               f_state_d  = F_ADDR;
            end else begin
               tx_load_c    = 1'b1;
               tx_byte_c    = REPLY_UNK;
               reply_left_d = '0;
               f_state_d    = F_REPLY;
            end
         end
         F_ADDR: begin
            if (timeout_c) begin
               f_state_d = F_IDLE;
            end else if (byte_valid_q) begin
               addr_d     = {addr_q[23:0], rx_shift_q};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) f_state_d = is_write_q ? F_DATA : F_EXEC;
            end
         end
         F_DATA: begin
            if (timeout_c) begin
               f_state_d = F_IDLE;
            end else if (byte_valid_q) begin
               wdata_d    = {wdata_q[23:0], rx_shift_q};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) f_state_d = F_EXEC;
            end
         end
         F_EXEC: begin
            tx_load_c = 1'b1;
            f_state_d = F_REPLY;
            if (is_write_q) begin
               tx_byte_c    = REPLY_ACK;
               reply_left_d = '0;
            end else begin
               tx_byte_c    = Read_data[31:24];
               reply_d      = Read_data[23:0];
               reply_left_d = 2'd3;
            end
         end
         F_REPLY: begin
            if (tx_done_c) begin
               if (reply_left_q != 2'd0) begin
                  tx_load_c    = 1'b1;
                  tx_byte_c    = reply_q[23:16];
                  reply_d      = {reply_q[15:0], 8'h00};
                  reply_left_d = reply_left_q - 2'd1;
               end else begin
                  f_state_d = F_IDLE;
               end
            end
         end
         default: f_state_d = F_IDLE;
      endcase
      mem_write_d = (f_state_d == F_EXEC) && is_write_d;
      mem_read_d  = (f_state_d == F_EXEC) && !is_write_d;
      busy_d      = (f_state_d != F_IDLE);
   end

   assign Tx_Serial  = tx_q;
   assign MemRead    = mem_read_q;
   assign MemWrite   = mem_write_q;
   assign Address    = addr_q;
   assign Write_data = wdata_q;
   assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: randomized frames against a frame-level reference model.
module tb_uart_bus_master;

   localparam int unsigned CPB       = 8;
   localparam int          BYTE_CLKS = 10 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        Rx_Serial;
   logic        Tx_Serial;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic [31:0] Read_data;
   logic        Busy;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   int          wr_cnt, rd_cnt, both_cnt, stop_err, strobe_cyc, busy_fall_cyc;
   logic [31:0] wr_addr, wr_data, rd_addr;
   logic        busy_prev = 1'b0;
   logic [7:0]  tx_q[$];
   int          tx_start[$];

   logic [7:0]  frame_q[$];
   logic [7:0]  exp_rep[$];
   int          exp_wr, exp_rd;
   logic [31:0] exp_addr, exp_wdata;

   uart_bus_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(200)) dut (
      .clk(clk), .reset(reset), .Rx_Serial(Rx_Serial), .Tx_Serial(Tx_Serial),
      .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .Write_data(Write_data),
      .Read_data(Read_data), .Busy(Busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus strobe and Busy observer
   always @(negedge clk) begin
      if (MemWrite) begin wr_cnt++; wr_addr = Address; wr_data = Write_data; strobe_cyc = cyc; end
      if (MemRead)  begin rd_cnt++; rd_addr = Address; strobe_cyc = cyc; end
      if (MemRead && MemWrite) both_cnt++;
      if (busy_prev && !Busy) busy_fall_cyc = cyc;
      busy_prev = Busy;
   end

   // Serial reply decoder, samples mid-bit
   initial begin : tx_mon
      int         s;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (!reset && Tx_Serial === 1'b0) begin
            s = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (CPB) @(negedge clk);
               b[k] = Tx_Serial;
            end
            repeat (CPB) @(negedge clk);
            if (Tx_Serial !== 1'b1) stop_err++;
            tx_q.push_back(b);
            tx_start.push_back(s);
         end
      end
   end

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation time limit reached, got hang want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      tick(1);
      Rx_Serial = 1'b0; tick(CPB);
      for (int i = 0; i < 8; i++) begin Rx_Serial = b[i]; tick(CPB); end
      Rx_Serial = stop_bit; tick(CPB);
      Rx_Serial = 1'b1;
   endtask

   task automatic clear_mon();
      wr_cnt = 0; rd_cnt = 0; both_cnt = 0; stop_err = 0;
      strobe_cyc = -1; busy_fall_cyc = -1;
      tx_q.delete(); tx_start.delete();
   endtask

   // Reference: what a well-formed frame must do on the bus and on the reply line
   function automatic void model(input logic [31:0] rd);
      exp_rep.delete();
      exp_wr = 0; exp_rd = 0; exp_addr = '0; exp_wdata = '0;
      if (frame_q[0] == 8'h57) begin
         exp_wr    = 1;
         exp_addr  = {frame_q[1], frame_q[2], frame_q[3], frame_q[4]};
         exp_wdata = {frame_q[5], frame_q[6], frame_q[7], frame_q[8]};
         exp_rep.push_back(8'h4B);
      end else if (frame_q[0] == 8'h52) begin
         exp_rd   = 1;
         exp_addr = {frame_q[1], frame_q[2], frame_q[3], frame_q[4]};
         for (int i = 3; i >= 0; i--) exp_rep.push_back(rd[8*i +: 8]);
      end else begin
         exp_rep.push_back(8'h3F);
      end
   endfunction

   task automatic run_frame(input logic [31:0] rd, output bit timed_out);
      int budget;
      Read_data = rd;
      clear_mon();
      foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
      budget = 0;
      while ((tx_q.size() < exp_rep.size() || Busy) && budget < 3000) begin
         @(negedge clk);
         budget++;
      end
      timed_out = (budget >= 3000);
      tick(4);
   endtask

   task automatic test_reset();
      reset = 1'b1; Rx_Serial = 1'b1; Read_data = '0;
      tick(5);
      reset = 1'b0;
      #1;
      n_cmp++; if (Tx_Serial !== 1'b1)   begin n_fail++; $display("FAIL reset_tx got %b want 1", Tx_Serial); end
      n_cmp++; if (MemRead !== 1'b0)     begin n_fail++; $display("FAIL reset_memread got %b want 0", MemRead); end
      n_cmp++; if (MemWrite !== 1'b0)    begin n_fail++; $display("FAIL reset_memwrite got %b want 0", MemWrite); end
      n_cmp++; if (Address !== 32'h0)    begin n_fail++; $display("FAIL reset_address got %h want 0", Address); end
      n_cmp++; if (Write_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", Write_data); end
      n_cmp++; if (Busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
      tick(3);
   endtask

   task automatic test_write();
      bit to;
      frame_q = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'hFF};
      model(32'h0);
      run_frame(32'hDEADBEEF, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL write_timeout got timeout want reply"); end
      n_cmp++; if (wr_cnt != 1) begin n_fail++; $display("FAIL write_count got %0d want 1", wr_cnt); end
      n_cmp++; if (rd_cnt != 0) begin n_fail++; $display("FAIL write_rdcount got %0d want 0", rd_cnt); end
      n_cmp++; if (wr_addr !== 32'h4000000C) begin n_fail++; $display("FAIL write_addr got %h want 4000000c", wr_addr); end
      n_cmp++; if (wr_data !== 32'h000000FF) begin n_fail++; $display("FAIL write_data got %h want 000000ff", wr_data); end
      n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin
         n_fail++; $display("FAIL write_reply got n=%0d b0=%h want n=1 4b", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
      end
      n_cmp++; if (tx_start.size() < 1 || tx_start[0] - strobe_cyc != 1) begin
         n_fail++; $display("FAIL write_latency got %0d want 1", (tx_start.size() > 0) ? tx_start[0] - strobe_cyc : -1);
      end
      n_cmp++; if (tx_start.size() < 1 || busy_fall_cyc - tx_start[0] != BYTE_CLKS) begin
         n_fail++; $display("FAIL write_busy_fall got %0d want %0d", busy_fall_cyc - ((tx_start.size() > 0) ? tx_start[0] : 0), BYTE_CLKS);
      end
      n_cmp++; if (Address !== 32'h4000000C) begin n_fail++; $display("FAIL write_addr_hold got %h want 4000000c", Address); end
   endtask

   task automatic test_read();
      bit to;
      frame_q = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h1C};
      model(32'h123456A5);
      run_frame(32'h123456A5, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL read_timeout got timeout want reply"); end
      n_cmp++; if (rd_cnt != 1 || wr_cnt != 0) begin n_fail++; $display("FAIL read_count got rd=%0d wr=%0d want rd=1 wr=0", rd_cnt, wr_cnt); end
      n_cmp++; if (rd_addr !== 32'h4000001C) begin n_fail++; $display("FAIL read_addr got %h want 4000001c", rd_addr); end
      n_cmp++; if (tx_q.size() != 4) begin n_fail++; $display("FAIL read_reply_len got %0d want 4", tx_q.size()); end
      for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
         n_cmp++; if (tx_q[i] !== exp_rep[i]) begin n_fail++; $display("FAIL read_byte%0d got %h want %h", i, tx_q[i], exp_rep[i]); end
      end
      for (int i = 1; i < tx_start.size(); i++) begin
         n_cmp++; if (tx_start[i] - tx_start[i-1] != BYTE_CLKS) begin
            n_fail++; $display("FAIL read_gap%0d got %0d want %0d", i, tx_start[i] - tx_start[i-1], BYTE_CLKS);
         end
      end
      n_cmp++; if (stop_err != 0) begin n_fail++; $display("FAIL read_stopbits got %0d bad want 0", stop_err); end
   endtask

   task automatic test_unknown_and_framing();
      bit to;
      int budget;
      clear_mon();
      send_byte(8'h00, 1'b1);
      n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL unknown_busy_rise got %b want 1", Busy); end
      budget = 0;
      while ((tx_q.size() < 1 || Busy) && budget < 2000) begin @(negedge clk); budget++; end
      n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'h3F) begin
         n_fail++; $display("FAIL unknown_reply got n=%0d b0=%h want n=1 3f", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
      end
      n_cmp++; if (wr_cnt + rd_cnt != 0) begin n_fail++; $display("FAIL unknown_strobe got %0d want 0", wr_cnt + rd_cnt); end
      // 'W' with a bad stop bit must vanish, leaving 'R' as the command
      clear_mon();
      send_byte(8'h57, 1'b0);
      tick(2 * CPB);
      n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL framing_busy got %b want 0", Busy); end
      frame_q = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h04};
      model(32'hA5C3_0F81);
      run_frame(32'hA5C3_0F81, to);
      n_cmp++; if (to || rd_cnt != 1 || wr_cnt != 0) begin
         n_fail++; $display("FAIL framing_read got to=%0d rd=%0d wr=%0d want to=0 rd=1 wr=0", to, rd_cnt, wr_cnt);
      end
      n_cmp++; if (tx_q.size() != 4 || tx_q[3] !== 8'h81) begin
         n_fail++; $display("FAIL framing_reply got n=%0d want n=4 last=81", tx_q.size());
      end
   endtask

   task automatic test_glitch();
      clear_mon();
      tick(1);
      Rx_Serial = 1'b0; tick(2);
      Rx_Serial = 1'b1; tick(15 * CPB);
      n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", Busy); end
      n_cmp++; if (tx_q.size() != 0 || wr_cnt + rd_cnt != 0) begin
         n_fail++; $display("FAIL glitch_activity got tx=%0d strobes=%0d want 0 0", tx_q.size(), wr_cnt + rd_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      bit to;
      int budget;
      clear_mon();
      send_byte(8'h57, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
      reset = 1'b1;
      #1;
      n_cmp++; if (Tx_Serial !== 1'b1 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL midframe_reset got tx=%b busy=%b want 1 0", Tx_Serial, Busy);
      end
      n_cmp++; if (Address !== 32'h0) begin n_fail++; $display("FAIL midframe_addr got %h want 0", Address); end
      tick(3);
      reset = 1'b0;
      tick(2);
      // reset while a reply character is on the line
      send_byte(8'h00, 1'b1);
      budget = 0;
      while (Tx_Serial !== 1'b0 && budget < 200) begin @(negedge clk); budget++; end
      repeat (20) @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++; if (budget >= 200 || Tx_Serial !== 1'b1 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL reply_reset got wait=%0d tx=%b busy=%b want tx=1 busy=0", budget, Tx_Serial, Busy);
      end
      tick(3);
      reset = 1'b0;
      tick(2 * BYTE_CLKS);
      n_cmp++; if (wr_cnt + rd_cnt != 0) begin n_fail++; $display("FAIL reset_no_strobe got %0d want 0", wr_cnt + rd_cnt); end
      frame_q = '{8'h57, 8'h80, 8'h00, 8'h00, 8'h20, 8'hCA, 8'hFE, 8'h12, 8'h34};
      model(32'h0);
      run_frame(32'h0, to);
      n_cmp++; if (to || wr_cnt != 1 || wr_addr !== exp_addr || wr_data !== exp_wdata) begin
         n_fail++; $display("FAIL post_reset_write got to=%0d n=%0d a=%h d=%h want n=1 a=%h d=%h", to, wr_cnt, wr_addr, wr_data, exp_addr, exp_wdata);
      end
   endtask

   task automatic test_dropped_bytes();
      bit to;
      int budget;
      frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
      model(32'h0BAD_F00D);
      Read_data = 32'h0BAD_F00D;
      clear_mon();
      foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
      send_byte(8'h57, 1'b1);
      budget = 0;
      while ((tx_q.size() < 4 || Busy) && budget < 3000) begin @(negedge clk); budget++; end
      tick(2 * BYTE_CLKS);
      n_cmp++; if (budget >= 3000 || Busy !== 1'b0) begin n_fail++; $display("FAIL dropped_busy got %b want 0", Busy); end
      n_cmp++; if (rd_cnt != 1 || wr_cnt != 0 || tx_q.size() != 4) begin
         n_fail++; $display("FAIL dropped_activity got rd=%0d wr=%0d tx=%0d want 1 0 4", rd_cnt, wr_cnt, tx_q.size());
      end
   endtask

   task automatic test_random();
      bit         to;
      logic [31:0] rdv;
      logic [7:0]  c;
      for (int n = 0; n < 8; n++) begin
         case ($urandom_range(0, 2))
            0: c = 8'h57;
            1: c = 8'h52;
            default: begin
               c = 8'($urandom_range(0, 255));
               if (c == 8'h57 || c == 8'h52) c = 8'h00;
            end
         endcase
         frame_q.delete();
         frame_q.push_back(c);
         if (c == 8'h57 || c == 8'h52) for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom_range(0, 255)));
         if (c == 8'h57) for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom_range(0, 255)));
         rdv = $urandom;
         model(rdv);
         run_frame(rdv, to);
         n_cmp++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout got timeout want reply", n); end
         n_cmp++; if (wr_cnt != exp_wr || rd_cnt != exp_rd || both_cnt != 0) begin
            n_fail++; $display("FAIL rand%0d_strobes got wr=%0d rd=%0d both=%0d want wr=%0d rd=%0d both=0", n, wr_cnt, rd_cnt, both_cnt, exp_wr, exp_rd);
         end
         if (exp_wr == 1) begin
            n_cmp++; if (wr_addr !== exp_addr || wr_data !== exp_wdata) begin
               n_fail++; $display("FAIL rand%0d_write got a=%h d=%h want a=%h d=%h", n, wr_addr, wr_data, exp_addr, exp_wdata);
            end
         end
         if (exp_rd == 1) begin
            n_cmp++; if (rd_addr !== exp_addr) begin n_fail++; $display("FAIL rand%0d_read_addr got %h want %h", n, rd_addr, exp_addr); end
         end
         n_cmp++; if (tx_q.size() != exp_rep.size()) begin
            n_fail++; $display("FAIL rand%0d_reply_len got %0d want %0d", n, tx_q.size(), exp_rep.size());
         end
         for (int i = 0; i < exp_rep.size() && i < tx_q.size(); i++) begin
            n_cmp++; if (tx_q[i] !== exp_rep[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d got %h want %h", n, i, tx_q[i], exp_rep[i]); end
         end
         if (exp_wr + exp_rd == 1 && tx_start.size() > 0) begin
            n_cmp++; if (tx_start[0] - strobe_cyc != 1) begin
               n_fail++; $display("FAIL rand%0d_latency got %0d want 1", n, tx_start[0] - strobe_cyc);
            end
         end
         if (tx_start.size() > 0) begin
            n_cmp++; if (busy_fall_cyc - tx_start[tx_start.size()-1] != BYTE_CLKS) begin
               n_fail++; $display("FAIL rand%0d_busy_fall got %0d want %0d", n, busy_fall_cyc - tx_start[tx_start.size()-1], BYTE_CLKS);
            end
         end
      end
   endtask

`ifdef UART_BRIDGE_TIMEOUT_EN
   task automatic test_timeout();
      bit to;
      clear_mon();
      send_byte(8'h57, 1'b1); send_byte(8'h40, 1'b1);
      tick(250);
      n_cmp++; if (Busy !== 1'b0 || wr_cnt + rd_cnt != 0 || tx_q.size() != 0) begin
         n_fail++; $display("FAIL timeout_abort got busy=%b strobes=%0d tx=%0d want 0 0 0", Busy, wr_cnt + rd_cnt, tx_q.size());
      end
      frame_q = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h30};
      model(32'h5566_7788);
      run_frame(32'h5566_7788, to);
      n_cmp++; if (to || rd_cnt != 1 || rd_addr !== 32'h40000030 || tx_q.size() != 4) begin
         n_fail++; $display("FAIL timeout_followup got rd=%0d a=%h tx=%0d want 1 40000030 4", rd_cnt, rd_addr, tx_q.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_unknown_and_framing();
      test_glitch();
      test_reset_midframe();
      test_dropped_bytes();
      test_random();
`ifdef UART_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
